geofence_sched: RTL

Round-robin scheduler that shares one `geofence` point-in-polygon engine among `NREQ` requesters. The engine has no input handshake and samples one point per cycle during fixed read windows. This block tracks the engine's frame phase and grants each window to one requester. It streams that requester's 7 points (test point, then 6 vertices) into the engine, fills idle windows with dummy frames, and returns each result tagged with the requester id. It sits between the requester ports and the engine's X/Y/valid/is_inside pins.

---
 rtl/geofence_sched.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/geofence_sched.sv
`default_nettype none
// ============================================================================
// Module   : geofence_sched
// Purpose  : Round-robin scheduler sharing one point-in-polygon engine among
//            NREQ requesters. It tracks the engine frame phase (7-cycle LOAD
//            window followed by WAIT for the result strobe). It streams the
//            granted requester's 7 points into the engine and fills idle
//            windows with dummy frames. Each result is returned tagged with
//            the owner id.
// Ports    : clk, reset (async, active-low; engine reset = ~reset outside)
//            req/req_x/req_y  - requester frame-ready flags and point slices
//            pt_ack           - one-hot point consumed strobe
//            eng_x/eng_y      - point bus to the engine
//            eng_valid/eng_inside - engine result strobe and value
//            res_valid/res_inside/res_id - tagged result, one-cycle strobe
//            busy             - a real frame is in flight
//            timeout_err      - sticky, a frame was abandoned
// Revision : 1.0 - initial release
// ============================================================================
module geofence_sched #(
  parameter int NREQ    = 4,
  parameter int IDW     = $clog2(NREQ),
  parameter int TIMEOUT = 63
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ*10-1:0] req_x,
  input  logic [NREQ*10-1:0] req_y,
  output logic [NREQ-1:0]    pt_ack,
  output logic [9:0]         eng_x,
  output logic [9:0]         eng_y,
  input  logic               eng_valid,
  input  logic               eng_inside,
  output logic               res_valid,
  output logic               res_inside,
  output logic [IDW-1:0]     res_id,
  output logic               busy,
  output logic               timeout_err
);

  // Counter must hold both the LOAD index (0..6) and the WAIT count.
  localparam int CW = ($clog2(TIMEOUT) > 3) ? $clog2(TIMEOUT) : 3;

  localparam logic [0:0] ST_LOAD = 1'b0;
  localparam logic [0:0] ST_WAIT = 1'b1;

  localparam logic [CW-1:0] LOAD_LAST = CW'(6);
  // WAIT counts 0..TIMEOUT-1, i.e. exactly TIMEOUT cycles before giving up.
  localparam logic [CW-1:0] WAIT_LAST = CW'(TIMEOUT - 1);

  logic [0:0]     state;
  logic [CW-1:0]  cnt;
  logic           owner_vld;
  logic [IDW-1:0] owner;
  logic [IDW-1:0] last;
  logic           grant_vld;
  logic [IDW-1:0] grant_id;

  // Requester index 'ofs' positions after 'base', wrapping at NREQ.
  function automatic logic [IDW-1:0] rr_idx(input logic [IDW-1:0] base, input int ofs);
    int s;
    s = int'(base) + ofs;
    if (s >= NREQ) s = s - NREQ;
    return s[IDW-1:0];
  endfunction

  // Round-robin search starting at last+1. Scanning from the farthest
  // candidate down lets the nearest requesting one overwrite the result.
  always_comb begin
    grant_vld = 1'b0;
    grant_id  = '0;
    for (int k = NREQ; k >= 1; k--) begin
      if (req[rr_idx(last, k)]) begin
        grant_vld = 1'b1;
        grant_id  = rr_idx(last, k);
      end
    end
  end

  // Point mux: during LOAD the owner's current point goes straight to the
  // engine and is acknowledged in the same cycle. Dummy frames drive zeros.
  always_comb begin
    pt_ack = '0;
    eng_x  = '0;
    eng_y  = '0;
    if (owner_vld && (state == ST_LOAD)) begin
      for (int i = 0; i < NREQ; i++) begin
        if (owner == i[IDW-1:0]) begin
          pt_ack[i] = 1'b1;
          eng_x     = req_x[10*i +: 10];
          eng_y     = req_y[10*i +: 10];
        end
      end
    end
  end

  // The state is always LOAD or WAIT, so only the owner flag matters.
  assign busy = owner_vld;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= ST_LOAD;
      cnt         <= '0;
      owner_vld   <= 1'b0;
      owner       <= '0;
      last        <= IDW'(NREQ - 1);
      res_valid   <= 1'b0;
      res_inside  <= 1'b0;
      res_id      <= '0;
      timeout_err <= 1'b0;
    end else begin
      res_valid <= 1'b0;
      case (state)
        ST_LOAD: begin
          // eng_valid here is a protocol error and is deliberately ignored.
          if (cnt == LOAD_LAST) begin
            state <= ST_WAIT;
            cnt   <= '0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: begin
          if (eng_valid || (cnt == WAIT_LAST)) begin
            if (eng_valid) begin
              // Dummy-frame results are dropped.
              if (owner_vld) begin
                res_valid  <= 1'b1;
                res_inside <= eng_inside;
                res_id     <= owner;
              end
            end else begin
              timeout_err <= 1'b1;
            end
            // Arbitrate for the next window; no request keeps 'last'.
            owner_vld <= grant_vld;
            if (grant_vld) begin
              owner <= grant_id;
              last  <= grant_id;
            end
            state <= ST_LOAD;
            cnt   <= '0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
      endcase
    end
  end

endmodule
`default_nettype wire
